// File: rtl/kf8259_interrupt_acknowledge_initiator_if.sv
// CPU-side bus between the KF8259 and the acknowledge initiator: request inputs, INTA#/lock, result handshake.
// master = initiator (drives INTA# and the result), slave = controller/consumer side.
interface kf8259_interrupt_acknowledge_initiator_if;
  logic        interrupt_request;
  logic        interrupt_enable;
  logic        mode_8086;
  logic [7:0]  data_bus_in;
  logic        interrupt_acknowledge_n;
  logic        bus_lock;
  logic        busy;
  logic        vector_valid;
  logic        vector_ready;
  logic [15:0] vector_out;
  logic [7:0]  opcode_out;

  modport master (
    input  interrupt_request, interrupt_enable, mode_8086, data_bus_in, vector_ready,
    output interrupt_acknowledge_n, bus_lock, busy, vector_valid, vector_out, opcode_out
  );

  modport slave (
    output interrupt_request, interrupt_enable, mode_8086, data_bus_in, vector_ready,
    input  interrupt_acknowledge_n, bus_lock, busy, vector_valid, vector_out, opcode_out
  );
endinterface

// File: rtl/kf8259_interrupt_acknowledge_initiator.sv
// Drives the 2/3-pulse INTA# sequence on an accepted KF8259 request and captures opcode/vector bytes.
// Result valid N*PW+(N-1)*GW+1 cycles after start; held in HOLD (no new sequence) until vector_ready.
module kf8259_interrupt_acknowledge_initiator #(
  parameter int PULSE_WIDTH = 2,
  parameter int GAP_WIDTH   = 2
) (
  input  logic clock,
  input  logic reset,
  kf8259_interrupt_acknowledge_initiator_if.master bus
);

  if (PULSE_WIDTH < 1 || PULSE_WIDTH > 255) begin : g_bad_pulse_width
    $error("PULSE_WIDTH must be within 1..255");
  end
  if (GAP_WIDTH < 1 || GAP_WIDTH > 255) begin : g_bad_gap_width
    $error("GAP_WIDTH must be within 1..255");
  end

  localparam logic [7:0] PULSE_LOAD = 8'(PULSE_WIDTH - 1);
  localparam logic [7:0] GAP_LOAD   = 8'(GAP_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, PULSE, GAP, HOLD} state_t;

  state_t     state, state_nxt;
  logic [7:0] count, count_nxt;
  logic [1:0] index, index_nxt;
  logic       mode_q, mode_nxt;
  logic       cap_opcode, cap_low, cap_high;
  logic       last_pulse;

  assign last_pulse = mode_q ? (index == 2'd1) : (index == 2'd2);

  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    index_nxt  = index;
    mode_nxt   = mode_q;
    cap_opcode = 1'b0;
    cap_low    = 1'b0;
    cap_high   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.interrupt_request && bus.interrupt_enable && !bus.vector_valid) begin
          mode_nxt  = bus.mode_8086;
          index_nxt = 2'd0;
          count_nxt = PULSE_LOAD;
          state_nxt = PULSE;
        end
      end
      PULSE: begin
        if (count == 8'd0) begin
          cap_opcode = (index == 2'd0);
          cap_low    = (index == 2'd1);
          cap_high   = (index == 2'd2);
          if (last_pulse) begin
            state_nxt = HOLD;
          end else begin
            count_nxt = GAP_LOAD;
            state_nxt = GAP;
          end
        end else begin
          count_nxt = count - 8'd1;
        end
      end
      GAP: begin
        if (count == 8'd0) begin
          index_nxt = index + 2'd1;
          count_nxt = PULSE_LOAD;
          state_nxt = PULSE;
        end else begin
          count_nxt = count - 8'd1;
        end
      end
      HOLD: begin
        if (bus.vector_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clock) begin
    if (reset) begin
      state                       <= IDLE;
      count                       <= 8'd0;
      index                       <= 2'd0;
      mode_q                      <= 1'b0;
      bus.interrupt_acknowledge_n <= 1'b1;
      bus.bus_lock                <= 1'b0;
      bus.busy                    <= 1'b0;
      bus.vector_valid            <= 1'b0;
      bus.vector_out              <= 16'h0000;
      bus.opcode_out              <= 8'h00;
    end else begin
      state                       <= state_nxt;
      count                       <= count_nxt;
      index                       <= index_nxt;
      mode_q                      <= mode_nxt;
      bus.interrupt_acknowledge_n <= (state_nxt != PULSE);
      bus.bus_lock                <= (state_nxt == PULSE) || (state_nxt == GAP);
      bus.busy                    <= (state_nxt != IDLE);
      bus.vector_valid            <= (state_nxt == HOLD);
      if (cap_opcode) bus.opcode_out <= bus.data_bus_in;
      // 8086 results carry a single vector byte; the upper byte is cleared with it.
      if (cap_low)    bus.vector_out <= {(mode_q ? 8'h00 : bus.vector_out[15:8]), bus.data_bus_in};
      if (cap_high)   bus.vector_out[15:8] <= bus.data_bus_in;
    end
  end

endmodule

// File: tb/tb_kf8259_interrupt_acknowledge_initiator.sv
// Two DUTs (PW/GW = 2/2 and 1/3) share stimulus; each has a timeline model plus literal checks.
module tb_kf8259_interrupt_acknowledge_initiator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       req   = 1'b0;
  logic       en    = 1'b0;
  logic       mode  = 1'b1;
  logic       ready = 1'b1;
  logic [7:0] bus_bytes [4];

  int vecs = 0;
  int errs = 0;

  wire        inta_w  [2];
  wire        lock_w  [2];
  wire        busy_w  [2];
  wire        valid_w [2];
  wire [15:0] vec_w   [2];
  wire [7:0]  op_w    [2];

  logic lg_inta  [2][40];
  logic lg_valid [2][40];
  logic lg_busy  [2][40];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    localparam int PW = (gi == 0) ? 2 : 1;
    localparam int GW = (gi == 0) ? 2 : 3;

    kf8259_interrupt_acknowledge_initiator_if ifc();

    kf8259_interrupt_acknowledge_initiator #(.PULSE_WIDTH(PW), .GAP_WIDTH(GW)) u_dut (
      .clock (clk),
      .reset (reset),
      .bus   (ifc)
    );

    assign ifc.interrupt_request = req;
    assign ifc.interrupt_enable  = en;
    assign ifc.mode_8086         = mode;
    assign ifc.vector_ready      = ready;
    assign inta_w[gi]  = ifc.interrupt_acknowledge_n;
    assign lock_w[gi]  = ifc.bus_lock;
    assign busy_w[gi]  = ifc.busy;
    assign valid_w[gi] = ifc.vector_valid;
    assign vec_w[gi]   = ifc.vector_out;
    assign op_w[gi]    = ifc.opcode_out;

    // Controller stand-in: presents bus_bytes[k] for the k-th pulse of a sequence.
    logic [1:0] idx  = 2'd0;
    logic       prev = 1'b1;
    always @(negedge clk) begin
      if (!ifc.busy) idx = 2'd0;
      else if (!prev && ifc.interrupt_acknowledge_n) idx = idx + 2'd1;
      prev = ifc.interrupt_acknowledge_n;
    end
    assign ifc.data_bus_in = bus_bytes[idx];

    // Timeline model: everything derives from the edge number of the accepted start.
    int         ec = 0;
    int         s0 = 0;
    int         rel, c, n, slen, p;
    bit         act = 1'b0;
    bit         md  = 1'b0;
    logic [7:0]  mop  = 8'h00;
    logic [15:0] mvec = 16'h0000;
    logic e_inta = 1'b1, e_lock = 1'b0, e_busy = 1'b0, e_valid = 1'b0;

    always @(posedge clk) begin
      ec++;
      if (reset) begin
        act  = 1'b0;
        mop  = 8'h00;
        mvec = 16'h0000;
      end else if (!act) begin
        if (req && en) begin
          act = 1'b1;
          s0  = ec;
          md  = mode;
        end
      end else begin
        n    = md ? 2 : 3;
        p    = PW + GW;
        slen = n * PW + (n - 1) * GW;
        rel  = ec - s0;
        for (int k = 0; k < n; k++) begin
          if (rel == PW + k * p) begin
            if (k == 0) mop = ifc.data_bus_in;
            else if (k == 1) mvec = md ? {8'h00, ifc.data_bus_in} : {mvec[15:8], ifc.data_bus_in};
            else mvec[15:8] = ifc.data_bus_in;
          end
        end
        if (rel > slen && ready) act = 1'b0;
      end
      e_inta = 1'b1; e_lock = 1'b0; e_busy = 1'b0; e_valid = 1'b0;
      if (act) begin
        n    = md ? 2 : 3;
        p    = PW + GW;
        slen = n * PW + (n - 1) * GW;
        c    = ec - s0 + 1;
        e_busy = 1'b1;
        if (c <= slen) begin
          e_inta = (((c - 1) % p) >= PW);
          e_lock = 1'b1;
        end else begin
          e_valid = 1'b1;
        end
      end
    end

    always @(negedge clk) begin
      if (ec > 0) begin
        chk($sformatf("inst%0d inta", gi),   16'(ifc.interrupt_acknowledge_n), 16'(e_inta));
        chk($sformatf("inst%0d lock", gi),   16'(ifc.bus_lock),                16'(e_lock));
        chk($sformatf("inst%0d busy", gi),   16'(ifc.busy),                    16'(e_busy));
        chk($sformatf("inst%0d valid", gi),  16'(ifc.vector_valid),            16'(e_valid));
        chk($sformatf("inst%0d vector", gi), ifc.vector_out,                   mvec);
        chk($sformatf("inst%0d opcode", gi), 16'(ifc.opcode_out),              16'(mop));
      end
    end
  end

  task automatic tick(input int cnt);
    repeat (cnt) @(posedge clk);
    #2;
  endtask

  // Records cycles 1..cnt after a start edge; optionally raises ready after cycle ready_at.
  task automatic log_cycles(input int cnt, input int ready_at);
    for (int cy = 1; cy <= cnt; cy++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        lg_inta[i][cy]  = inta_w[i];
        lg_valid[i][cy] = valid_w[i];
        lg_busy[i][cy]  = busy_w[i];
      end
      if (cy == ready_at) ready = 1'b1;
    end
  endtask

  initial begin
    bus_bytes = '{8'h00, 8'h00, 8'h00, 8'h00};
    tick(3);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("reset inta",   16'(inta_w[i]),  16'h1);
      chk("reset busy",   16'(busy_w[i]),  16'h0);
      chk("reset valid",  16'(valid_w[i]), 16'h0);
      chk("reset vector", vec_w[i],        16'h0000);
      chk("reset opcode", 16'(op_w[i]),    16'h00);
    end
    @(posedge clk); #2;
    reset = 1'b0; en = 1'b1; mode = 1'b1; ready = 1'b1;
    bus_bytes = '{8'hFF, 8'h4B, 8'h00, 8'h00};
    tick(2);

    // 8086, request dropped right after start: the sequence still completes
    req = 1'b1; tick(1); req = 1'b0;
    log_cycles(12, 0);
    for (int cy = 1; cy <= 12; cy++) begin
      chk("t1 inta u0",  16'(lg_inta[0][cy]),  16'(!(cy inside {1, 2, 5, 6})));
      chk("t1 valid u0", 16'(lg_valid[0][cy]), 16'(cy == 7));
      chk("t1 inta u1",  16'(lg_inta[1][cy]),  16'(!(cy inside {1, 5})));
      chk("t1 valid u1", 16'(lg_valid[1][cy]), 16'(cy == 6));
    end
    chk("t1 vector u0", vec_w[0],     16'h004B);
    chk("t1 opcode u0", 16'(op_w[0]), 16'h00FF);
    chk("t1 vector u1", vec_w[1],     16'h004B);

    // 8080: three pulses, CALL opcode and two address bytes
    @(posedge clk); #2;
    mode = 1'b0; bus_bytes = '{8'hCD, 8'h34, 8'h12, 8'h00};
    req = 1'b1; tick(1); req = 1'b0;
    log_cycles(16, 0);
    for (int cy = 1; cy <= 16; cy++) begin
      chk("t2 inta u0",  16'(lg_inta[0][cy]),  16'(!(cy inside {1, 2, 5, 6, 9, 10})));
      chk("t2 valid u0", 16'(lg_valid[0][cy]), 16'(cy == 11));
      chk("t2 inta u1",  16'(lg_inta[1][cy]),  16'(!(cy inside {1, 5, 9})));
      chk("t2 valid u1", 16'(lg_valid[1][cy]), 16'(cy == 10));
    end
    chk("t2 vector u0", vec_w[0],     16'h1234);
    chk("t2 opcode u0", 16'(op_w[0]), 16'h00CD);
    chk("t2 vector u1", vec_w[1],     16'h1234);

    // Backpressure: valid held with request high, restart on first IDLE cycle
    @(posedge clk); #2;
    mode = 1'b1; ready = 1'b0; bus_bytes = '{8'h11, 8'h22, 8'h33, 8'h00};
    req = 1'b1; tick(1);
    log_cycles(20, 12);
    for (int cy = 7; cy <= 12; cy++) chk("t3 valid held u0", 16'(lg_valid[0][cy]), 16'h1);
    for (int cy = 7; cy <= 13; cy++) chk("t3 no pulse u0", 16'(lg_inta[0][cy]), 16'h1);
    for (int cy = 6; cy <= 12; cy++) chk("t3 valid held u1", 16'(lg_valid[1][cy]), 16'h1);
    for (int i = 0; i < 2; i++) begin
      chk("t3 idle busy",  16'(lg_busy[i][13]),  16'h0);
      chk("t3 idle valid", 16'(lg_valid[i][13]), 16'h0);
      chk("t3 restart",    16'(lg_inta[i][14]),  16'h0);
    end
    @(posedge clk); #2;
    req = 1'b0;
    tick(30);

    // Interrupts disabled: request ignored, then enable starts at the next edge
    en = 1'b0; req = 1'b1;
    log_cycles(20, 0);
    for (int cy = 1; cy <= 20; cy++) begin
      chk("t4 inta off", 16'(lg_inta[0][cy] & lg_inta[1][cy]), 16'h1);
      chk("t4 busy off", 16'(lg_busy[0][cy] | lg_busy[1][cy]), 16'h0);
    end
    @(posedge clk); #2;
    en = 1'b1; tick(1); req = 1'b0;
    log_cycles(2, 0);
    for (int i = 0; i < 2; i++) begin
      chk("t4 start inta", 16'(lg_inta[i][1]), 16'h0);
      chk("t4 start busy", 16'(lg_busy[i][1]), 16'h1);
    end
    tick(30);

    // Reset during the gap
    bus_bytes = '{8'h5A, 8'h6B, 8'h7C, 8'h00};
    req = 1'b1; tick(1); req = 1'b0;
    log_cycles(2, 0);
    @(posedge clk); #2; reset = 1'b1;
    @(posedge clk); #2; reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("t5 inta",   16'(inta_w[i]), 16'h1);
      chk("t5 lock",   16'(lock_w[i]), 16'h0);
      chk("t5 busy",   16'(busy_w[i]), 16'h0);
      chk("t5 vector", vec_w[i],       16'h0000);
    end
    log_cycles(10, 0);
    for (int cy = 1; cy <= 10; cy++) chk("t5 no pulse", 16'(lg_inta[0][cy] & lg_inta[1][cy]), 16'h1);

    // Randomized traffic against the models
    for (int t = 0; t < 3000; t++) begin
      @(posedge clk); #2;
      reset = ($urandom_range(0, 299) == 0);
      req   = ($urandom_range(0, 3) != 0);
      en    = ($urandom_range(0, 7) != 0);
      mode  = $urandom_range(0, 1) != 0;
      ready = ($urandom_range(0, 2) != 0);
      for (int b = 0; b < 4; b++) bus_bytes[b] = 8'($urandom);
    end
    @(posedge clk); #2;
    reset = 1'b0; req = 1'b0; ready = 1'b1;
    tick(40);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/kf8259_interrupt_acknowledge_initiator.md
# kf8259_interrupt_acknowledge_initiator

CPU-side counterpart of the KF8259 interrupt controller: watches the controller's interrupt request output and, when the CPU accepts interrupts, drives the interrupt-acknowledge pulse sequence, then captures the vector or CALL address the controller places on the data bus. It sits between the KF8259 and the CPU core or testbench CPU model. It delivers the captured result through a valid/ready handshake. It supports both 8086 mode (two pulses) and 8080/8085 mode (three pulses).

## Interface
- PULSE_WIDTH, 2: cycles interrupt_acknowledge_n is held low per pulse; legal range 1..255.
- GAP_WIDTH, 2: cycles interrupt_acknowledge_n is held high between pulses; legal range 1..255.
- clock  input  1  single clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high.
- interrupt_request  input  1  INT from the KF8259; level, active-high.
- interrupt_enable  input  1  CPU interrupt flag; requests are ignored while low.
- mode_8086  input  1  1 selects 8086 (2 pulses), 0 selects 8080 (3 pulses); sampled only on sequence start.
- data_bus_in  input  8  KF8259 data bus output.
- interrupt_acknowledge_n  output  1  INTA#, active-low.
- bus_lock  output  1  high from the first pulse start to the final pulse end.
- busy  output  1  high whenever the state is not IDLE.
- vector_valid  output  1  captured result available.
- vector_ready  input  1  consumer accepts the result.
- vector_out  output  16  8086 mode: {8'h00, byte2}; 8080 mode: {byte3, byte2}.
- opcode_out  output  8  byte on the bus during pulse 1 (8080: CALL 8'hCD; 8086: don't-care, captured anyway).

## Operation
- States:
  - IDLE: start condition is interrupt_request & interrupt_enable & !vector_valid. On start: latch mode_8086, load the pulse index (0), load the width counter with PULSE_WIDTH-1, go to PULSE.
  - PULSE: interrupt_acknowledge_n = 0. Counter decrements each cycle. On the cycle the counter is 0:
    - capture data_bus_in into the byte slot for the current pulse index (0→opcode_out, 1→vector_out[7:0], 2→vector_out[15:8]);
    - if this is the last pulse (index 1 in 8086 mode, 2 in 8080 mode), go to HOLD;
    - otherwise load GAP_WIDTH-1 and go to GAP.
  - GAP: interrupt_acknowledge_n = 1, bus_lock stays 1. When the counter reaches 0: increment the index, load PULSE_WIDTH-1, go to PULSE.
  - HOLD: vector_valid = 1, busy = 1, bus_lock = 0. When vector_ready = 1, go to IDLE; vector_valid deasserts next cycle.
- In 8086 mode, vector_out[15:8] is forced to 0 at capture of byte2.
- Once started, the sequence always completes. Deassertion of interrupt_request or interrupt_enable mid-sequence is ignored; the KF8259 supplies its own spurious vector.
- A start condition present in the same cycle the HOLD handshake completes is not taken. The earliest new start is the first IDLE cycle.
- Captured outputs (vector_out, opcode_out) hold their value until overwritten by the next sequence.
- Reset, including mid-sequence: next state is IDLE; interrupt_acknowledge_n = 1, bus_lock = 0, busy = 0, vector_valid = 0, vector_out = 16'h0000, opcode_out = 8'h00, counters = 0.
- Counters are 8-bit. Parameter values outside 1..255 are a compile-time error via an elaboration assertion.

## Timing
- Cycle 0 is the edge where the start condition is sampled in IDLE. All outputs are registered.
- Pulse k (k = 0,1,2) spans cycles 1 + k·(PW+GW) through PW + k·(PW+GW).
- Capture for a pulse happens at the closing edge of that pulse's last low cycle. data_bus_in must be stable on that cycle.
- vector_valid rises on cycle 1 + N·PW + (N−1)·GW, where N = 2 (8086) or 3 (8080).
  - Defaults, 8086: INTA# low on cycles 1–2 and 5–6; vector_valid on cycle 7.
  - Defaults, 8080: INTA# low on cycles 1–2, 5–6 and 9–10; vector_valid on cycle 11.
- bus_lock: high from cycle 1 through the last low cycle of the final pulse.
- busy: high from cycle 1 until the cycle after the handshake.
- Handshake: if vector_ready is already high on the first HOLD cycle, vector_valid is high for exactly 1 cycle.
- Minimum request-to-request spacing is one IDLE cycle.

## Test plan
- 8086 mode, defaults, interrupt_request held high, vector_ready = 1; bus shows 8'hFF on pulse 1 and 8'h4B on pulse 2:
  - INTA# low on cycles 1–2 and 5–6;
  - vector_valid for one cycle at 7 with vector_out = 16'h004B;
  - opcode_out = 8'hFF.
- 8080 mode; bus shows 8'hCD, 8'h34, 8'h12 on pulses 1–3:
  - three pulses;
  - opcode_out = 8'hCD, vector_out = 16'h1234, vector_valid at cycle 11.
- vector_ready held low for 5 cycles with interrupt_request still high:
  - vector_valid stays high and no new INTA# pulse occurs;
  - after the accept, the next sequence starts on the first IDLE cycle.
- interrupt_enable = 0 with interrupt_request = 1 for 20 cycles:
  - INTA# stays high and busy stays 0;
  - raising interrupt_enable starts the sequence at the next edge.
- PULSE_WIDTH = 1, GAP_WIDTH = 3, 8086 mode: INTA# low on cycles 1 and 5, vector_valid at cycle 6.
- Reset asserted during the GAP state: the next cycle shows INTA# = 1, bus_lock = 0, busy = 0, vector_out = 0, and no further pulse occurs.
